// File: rtl/elevator_car_plant_if.sv
// Car-control interface: the elevator controller (master) drives motion/door
// command levels, the car plant (slave) reports floor, alignment, door and fault status.
interface elevator_car_plant_if #(
  parameter int N = 5
);
  localparam int FW = $clog2(N + 1);

  logic          go_up_cmd;
  logic          go_down_cmd;
  logic          door_open_cmd;
  logic [FW-1:0] car_floor;
  logic          at_floor;
  logic          arrive_pulse;
  logic          moving_up;
  logic          moving_down;
  logic          door_closed;
  logic          door_opened;
  logic          fault;

  modport master (
    output go_up_cmd, go_down_cmd, door_open_cmd,
    input  car_floor, at_floor, arrive_pulse, moving_up, moving_down,
           door_closed, door_opened, fault
  );

  modport slave (
    input  go_up_cmd, go_down_cmd, door_open_cmd,
    output car_floor, at_floor, arrive_pulse, moving_up, moving_down,
           door_closed, door_opened, fault
  );
endinterface

// File: rtl/elevator_car_plant.sv
// Elevator car plant: times floor-to-floor travel and door strokes on a prescaled tick.
// Optional feature macro: CAR_FAULT_LATCH_EN (sticky fault that blocks motion starts).
module elevator_car_plant #(
  parameter int N                  = 5,
  parameter int board_freq         = 50000000,
  parameter int tick_freq          = 10,
  parameter int floor_travel_ticks = 20,
  parameter int door_move_ticks    = 5
) (
  input logic                 board_clk,
  input logic                 rst_n,
  elevator_car_plant_if.slave car_if
);

  localparam int PRESCALE = board_freq / tick_freq;
  localparam int FW = $clog2(N + 1);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (floor_travel_ticks > 1) ? $clog2(floor_travel_ticks) : 1;
  localparam int DW = (door_move_ticks > 1) ? $clog2(door_move_ticks) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SEG_LAST  = SW'(floor_travel_ticks - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(door_move_ticks - 1);
  localparam logic [FW-1:0] FLOOR_TOP = FW'(N);
  localparam logic [FW-1:0] FLOOR_BOT = FW'(1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_MOVE_UP      = 3'd1,
    S_MOVE_DOWN    = 3'd2,
    S_DOOR_OPENING = 3'd3,
    S_DOOR_OPEN    = 3'd4,
    S_DOOR_CLOSING = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q;
  logic [SW-1:0] seg_q, seg_d;
  logic [DW-1:0] door_cnt_q, door_cnt_d;
  logic [FW-1:0] floor_q, floor_d;
  logic          tick_s;
  logic          offend_s;
  logic          arrive_s;
  logic          motion_block_s;

  logic at_floor_q, at_floor_d;
  logic arrive_q, arrive_d;
  logic moving_up_q, moving_up_d;
  logic moving_down_q, moving_down_d;
  logic door_closed_q, door_closed_d;
  logic door_opened_q, door_opened_d;
  logic fault_q, fault_d;

  // One-floor step that can never leave the 1..N range.
  function automatic logic [FW-1:0] step_floor(input logic [FW-1:0] f, input logic up);
    if (up) begin
      return (f < FLOOR_TOP) ? (f + FW'(1)) : FLOOR_TOP;
    end else begin
      return (f > FLOOR_BOT) ? (f - FW'(1)) : FLOOR_BOT;
    end
  endfunction

`ifdef CAR_FAULT_LATCH_EN
  assign motion_block_s = fault_q;
`else
  assign motion_block_s = 1'b0;
`endif

  // Free-running prescaler; tick_s marks the last count of each period.
  always_ff @(posedge board_clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= {PW{1'b0}};
    end else if (pre_q == PRE_LAST) begin
      pre_q <= {PW{1'b0}};
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  assign tick_s = (pre_q == PRE_LAST);

  // State, counters and registered outputs.
  always_ff @(posedge board_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      seg_q         <= {SW{1'b0}};
      door_cnt_q    <= {DW{1'b0}};
      floor_q       <= FLOOR_BOT;
      at_floor_q    <= 1'b1;
      arrive_q      <= 1'b0;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
      door_closed_q <= 1'b1;
      door_opened_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      seg_q         <= seg_d;
      door_cnt_q    <= door_cnt_d;
      floor_q       <= floor_d;
      at_floor_q    <= at_floor_d;
      arrive_q      <= arrive_d;
      moving_up_q   <= moving_up_d;
      moving_down_q <= moving_down_d;
      door_closed_q <= door_closed_d;
      door_opened_q <= door_opened_d;
      fault_q       <= fault_d;
    end
  end

  // Next-state logic: commands act every cycle, travel/stroke counters advance on tick.
  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    door_cnt_d = door_cnt_q;
    floor_d    = floor_q;
    offend_s   = 1'b0;
    arrive_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (car_if.door_open_cmd) begin
          state_d    = S_DOOR_OPENING;
          door_cnt_d = {DW{1'b0}};
        end else if (car_if.go_up_cmd && car_if.go_down_cmd) begin
          offend_s = 1'b1;
        end else if (car_if.go_up_cmd) begin
          if (floor_q >= FLOOR_TOP) begin
            offend_s = 1'b1;
          end else if (!motion_block_s) begin
            state_d = S_MOVE_UP;
            seg_d   = {SW{1'b0}};
          end else begin
            state_d = S_IDLE;
          end
        end else if (car_if.go_down_cmd) begin
          if (floor_q <= FLOOR_BOT) begin
            offend_s = 1'b1;
          end else if (!motion_block_s) begin
            state_d = S_MOVE_DOWN;
            seg_d   = {SW{1'b0}};
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MOVE_UP, S_MOVE_DOWN: begin
        // A segment always completes; direction commands are not looked at here.
        offend_s = car_if.door_open_cmd;
        if (tick_s && (seg_q == SEG_LAST)) begin
          seg_d    = {SW{1'b0}};
          arrive_s = 1'b1;
          state_d  = S_IDLE;
          floor_d  = step_floor(floor_q, state_q == S_MOVE_UP);
        end else if (tick_s) begin
          seg_d = seg_q + SW'(1);
        end else begin
          seg_d = seg_q;
        end
      end
      S_DOOR_OPENING: begin
        offend_s = car_if.go_up_cmd | car_if.go_down_cmd;
        if (tick_s && (door_cnt_q == DOOR_LAST)) begin
          state_d    = S_DOOR_OPEN;
          door_cnt_d = {DW{1'b0}};
        end else if (tick_s) begin
          door_cnt_d = door_cnt_q + DW'(1);
        end else begin
          door_cnt_d = door_cnt_q;
        end
      end
      S_DOOR_OPEN: begin
        offend_s = car_if.go_up_cmd | car_if.go_down_cmd;
        if (!car_if.door_open_cmd) begin
          state_d    = S_DOOR_CLOSING;
          door_cnt_d = {DW{1'b0}};
        end else begin
          state_d = S_DOOR_OPEN;
        end
      end
      S_DOOR_CLOSING: begin
        // Reopening restarts a full stroke rather than reversing from mid-travel.
        offend_s = car_if.go_up_cmd | car_if.go_down_cmd;
        if (car_if.door_open_cmd) begin
          state_d    = S_DOOR_OPENING;
          door_cnt_d = {DW{1'b0}};
        end else if (tick_s && (door_cnt_q == DOOR_LAST)) begin
          state_d    = S_IDLE;
          door_cnt_d = {DW{1'b0}};
        end else if (tick_s) begin
          door_cnt_d = door_cnt_q + DW'(1);
        end else begin
          door_cnt_d = door_cnt_q;
        end
      end
      default: begin
        state_d    = S_IDLE;
        seg_d      = {SW{1'b0}};
        door_cnt_d = {DW{1'b0}};
        floor_d    = FLOOR_BOT;
      end
    endcase
  end

  // Output decode from the next state so registered outputs track the new state.
  always_comb begin
    moving_up_d   = 1'b0;
    moving_down_d = 1'b0;
    door_closed_d = 1'b1;
    door_opened_d = 1'b0;
    case (state_d)
      S_IDLE:         door_closed_d = 1'b1;
      S_MOVE_UP:      moving_up_d   = 1'b1;
      S_MOVE_DOWN:    moving_down_d = 1'b1;
      S_DOOR_OPENING: door_closed_d = 1'b0;
      S_DOOR_CLOSING: door_closed_d = 1'b0;
      S_DOOR_OPEN: begin
        door_closed_d = 1'b0;
        door_opened_d = 1'b1;
      end
      default: begin
        moving_up_d   = 1'b0;
        moving_down_d = 1'b0;
        door_closed_d = 1'b1;
        door_opened_d = 1'b0;
      end
    endcase
    at_floor_d = !(moving_up_d || moving_down_d);
    arrive_d   = arrive_s;
`ifdef CAR_FAULT_LATCH_EN
    fault_d    = fault_q | offend_s;
`else
    fault_d    = offend_s;
`endif
  end

  assign car_if.car_floor    = floor_q;
  assign car_if.at_floor     = at_floor_q;
  assign car_if.arrive_pulse = arrive_q;
  assign car_if.moving_up    = moving_up_q;
  assign car_if.moving_down  = moving_down_q;
  assign car_if.door_closed  = door_closed_q;
  assign car_if.door_opened  = door_opened_q;
  assign car_if.fault        = fault_q;

endmodule

// File: tb/tb_elevator_car_plant.sv
// Self-checking bench for elevator_car_plant: directed vector table, hand sequences,
// and randomized command bursts against a position/stroke based reference model.
module tb_elevator_car_plant;
  localparam int N          = 5;
  localparam int BOARD_FREQ = 40;
  localparam int TICK_FREQ  = 10;
  localparam int FT         = 3;
  localparam int DT         = 2;
  localparam int PRESCALE   = BOARD_FREQ / TICK_FREQ;
`ifdef CAR_FAULT_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic board_clk = 1'b0;
  logic rst_n     = 1'b0;

  elevator_car_plant_if #(.N(N)) car_if ();

  elevator_car_plant #(
    .N(N), .board_freq(BOARD_FREQ), .tick_freq(TICK_FREQ),
    .floor_travel_ticks(FT), .door_move_ticks(DT)
  ) dut (
    .board_clk(board_clk),
    .rst_n(rst_n),
    .car_if(car_if)
  );

  always #5 board_clk = ~board_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: car position in ticks of travel, door position in ticks of stroke.
  int m_floor, m_dir, m_prog, m_door, m_ddir, m_cyc;
  bit m_arr, m_fault;

  typedef struct {
    bit up; bit dn; bit dr; int cyc;
    int fl; bit at; bit arr; bit mu; bit md; bit dc; bit dop; bit flt;
  } vec_t;
  vec_t tbl[23];

  function automatic int pack(input int fl, input bit at, input bit arr, input bit mu,
                              input bit md, input bit dc, input bit dop, input bit flt);
    return (fl << 7) | (int'(at) << 6) | (int'(arr) << 5) | (int'(mu) << 4) |
           (int'(md) << 3) | (int'(dc) << 2) | (int'(dop) << 1) | int'(flt);
  endfunction

  function automatic int dut_vec();
    return pack(int'(car_if.car_floor), car_if.at_floor, car_if.arrive_pulse, car_if.moving_up,
                car_if.moving_down, car_if.door_closed, car_if.door_opened, car_if.fault);
  endfunction

  function automatic int model_vec();
    return pack(m_floor, m_dir == 0, m_arr, m_dir == 1, m_dir == -1,
                (m_door == 0) && (m_ddir == 0), (m_door == DT) && (m_ddir == 0), m_fault);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_floor = 1; m_dir = 0; m_prog = 0; m_door = 0; m_ddir = 0;
    m_cyc = 0; m_arr = 1'b0; m_fault = 1'b0;
  endtask

  task automatic model_step(input bit up, input bit dn, input bit dr);
    bit tick, off, blocked;
    tick    = (m_cyc % PRESCALE) == (PRESCALE - 1);
    m_cyc++;
    blocked = LATCH && m_fault;
    off     = 1'b0;
    m_arr   = 1'b0;
    if (m_dir != 0) begin
      off = dr;
      if (tick) begin
        m_prog++;
        if (m_prog == FT) begin
          m_floor += m_dir; m_dir = 0; m_prog = 0; m_arr = 1'b1;
        end
      end
    end else if (m_door == 0 && m_ddir == 0) begin
      if (dr) m_ddir = 1;
      else if (up && dn) off = 1'b1;
      else if (up) begin
        if (m_floor == N) off = 1'b1;
        else if (!blocked) m_dir = 1;
      end else if (dn) begin
        if (m_floor == 1) off = 1'b1;
        else if (!blocked) m_dir = -1;
      end
    end else begin
      off = up | dn;
      if (m_ddir == 1) begin
        if (tick) begin
          m_door++;
          if (m_door == DT) m_ddir = 0;
        end
      end else if (m_ddir == -1) begin
        if (dr) begin
          m_door = 0; m_ddir = 1;
        end else if (tick) begin
          m_door--;
          if (m_door == 0) m_ddir = 0;
        end
      end else if (!dr) begin
        m_ddir = -1;
      end
    end
    m_fault = LATCH ? (m_fault | off) : off;
  endtask

  task automatic cycle(input bit up, input bit dn, input bit dr);
    car_if.go_up_cmd     = up;
    car_if.go_down_cmd   = dn;
    car_if.door_open_cmd = dr;
    @(posedge board_clk);
    model_step(up, dn, dr);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    check("rst_floor", int'(car_if.car_floor), 1);
    check("rst_at_floor", int'(car_if.at_floor), 1);
    check("rst_moving", int'({car_if.moving_up, car_if.moving_down}), 0);
    check("rst_door", int'({car_if.door_closed, car_if.door_opened}), 2);
    check("rst_arrive_fault", int'({car_if.arrive_pulse, car_if.fault}), 0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic climb_to(input int target);
    for (int f = 0; f < N && m_floor < target; f++) begin
      int n, exp_floor;
      bit seen;
      exp_floor = m_floor + 1;
      seen = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin
        cycle(1'b1, 1'b0, 1'b0);
        seen = car_if.moving_up;
      end
      check("move_start", int'(seen), 1);
      seen = 1'b0;
      n = 0;
      for (int k = 0; k < 16 && !seen; k++) begin
        cycle(1'b1, 1'b0, 1'b0);
        n++;
        seen = car_if.arrive_pulse;
      end
      check("arrive_seen", int'(seen), 1);
      check("arrive_latency_9_12", n, (n >= 9 && n <= 12) ? n : 9);
      check("arrive_floor", int'(car_if.car_floor), exp_floor);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    car_if.go_up_cmd     = 1'b0;
    car_if.go_down_cmd   = 1'b0;
    car_if.door_open_cmd = 1'b0;
    //            up    dn    dr    cyc fl at    arr   mu    md    dc    dop   flt
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1,  1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1,  1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 7,  1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 3,  2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 4,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 2,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 7,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 7,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1,  2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 1,  2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 10, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 1,  1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 10, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1,  2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 1,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Power-on reset values, observed before any clock edge releases reset.
    #12;
    check("por_state", dut_vec(), pack(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    model_reset();
    rst_n = 1'b1;

`ifndef CAR_FAULT_LATCH_EN
    // Directed table; expected values are hand-derived from the tick phase after reset.
    for (int i = 0; i < 23; i++) begin
      for (int c = 0; c < tbl[i].cyc; c++) cycle(tbl[i].up, tbl[i].dn, tbl[i].dr);
      check($sformatf("row%0d", i), dut_vec(),
            pack(tbl[i].fl, tbl[i].at, tbl[i].arr, tbl[i].mu, tbl[i].md,
                 tbl[i].dc, tbl[i].dop, tbl[i].flt));
    end
`endif

    // Climb to the top floor, then overtravel must fault without motion.
    climb_to(N);
    cycle(1'b1, 1'b0, 1'b0);
    check("overtravel_fault", int'(car_if.fault), 1);
    check("overtravel_no_move", int'(car_if.moving_up), 0);
    check("overtravel_floor", int'(car_if.car_floor), N);
    cycle(1'b1, 1'b0, 1'b0);
    check("overtravel_fault_held", int'(car_if.fault), 1);
    cycle(1'b0, 1'b0, 1'b0);
    check("fault_after_release", int'(car_if.fault), LATCH ? 1 : 0);
    cycle(1'b0, 1'b1, 1'b0);
    check("down_after_fault", int'(car_if.moving_down), LATCH ? 0 : 1);
    reset_pulse();

    // Reset while travelling 3 -> 4 snaps the car to floor 1 without a clock.
    climb_to(3);
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b0);
    check("mid_move_up", int'(car_if.moving_up), 1);
    check("mid_move_floor", int'(car_if.car_floor), 3);
    reset_pulse();

    // Conflicting directions at floor 3.
    climb_to(3);
    cycle(1'b1, 1'b1, 1'b0);
    check("both_fault", int'(car_if.fault), 1);
    check("both_floor", int'(car_if.car_floor), 3);
    check("both_at_floor", int'(car_if.at_floor), 1);
    cycle(1'b0, 1'b0, 1'b0);

    // Randomized command bursts against the model.
    for (int c = 0; c < 1500; ) begin
      int sel, len;
      bit up, dn, dr;
      sel = $urandom_range(0, 11);
      len = $urandom_range(1, 14);
      up = (sel <= 2) || (sel == 6) || (sel == 10);
      dn = (sel >= 3 && sel <= 5) || (sel == 6);
      dr = (sel == 7) || (sel == 8) || (sel == 10);
      for (int k = 0; k < len; k++) begin
        cycle(up, dn, dr);
        c++;
      end
      if ($urandom_range(0, 60) == 0) reset_pulse();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
